// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel UART receiver.
//   Oversamples the synchronized RxD line at OVERSAMPLE ticks per bit and takes a
//   3-sample majority vote around mid-bit. Recovered bytes are presented on data_o
//   with a one-cycle valid_o pulse; a stop bit sampled low gives a one-cycle
//   frame_err_o pulse instead.
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   rxd_i        serial input, asynchronous to clk_i, idles high
//   data_o       last correctly framed byte, held until the next one
//   valid_o      one-cycle pulse: data_o holds a new byte
//   frame_err_o  one-cycle pulse: stop bit sampled 0
//   busy_o       high whenever the receiver is not idle
module uart_receiver #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SampW    = $clog2(OVERSAMPLE);

  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [SampW-1:0] SampMidLo = SampW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampW-1:0] SampMid   = SampW'(OVERSAMPLE / 2);
  localparam logic [SampW-1:0] SampMidHi = SampW'(OVERSAMPLE / 2 + 1);
  localparam logic [SampW-1:0] SampLast  = SampW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SampW-1:0] samp_cnt_q, samp_cnt_d;
  logic [1:0]       maj_q, maj_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic tick, decide, bit_end, bit_val;

  // Two-flop synchronizer; reset high so a reset release never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      maj_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      maj_q      <= maj_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Tick is gated by state so a TICK_DIV of 1 cannot fire while idle.
  assign tick    = (state_q != StIdle) && (tick_cnt_q == TickLast);
  assign decide  = tick && (samp_cnt_q == SampMidHi);
  assign bit_end = tick && (samp_cnt_q == SampLast);
  // Majority of the two stored samples and the current one at the decision tick.
  assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s_q) | (maj_q[1] & rx_s_q);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    samp_cnt_d = samp_cnt_q;
    maj_d      = maj_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    // Counters sit at zero while idle, so the cycle the start edge is seen begins
    // a fresh tick/sample count.
    if (state_q == StIdle) begin
      tick_cnt_d = '0;
      samp_cnt_d = '0;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        samp_cnt_d = (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + 1'b1;
        if (samp_cnt_q == SampMidLo) maj_d[0] = rx_s_q;
        if (samp_cnt_q == SampMid)   maj_d[1] = rx_s_q;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Reaching bit end here implies the mid-bit vote was 0.
        if (decide && bit_val) begin
          state_d = StIdle;
        end else if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (decide) begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (bit_end && (bit_cnt_q == 4'd8)) state_d = StStop;
      end
      StStop: begin
        // Leave at mid-stop to give half a bit of margin for a back-to-back start.
        if (decide) begin
          if (bit_val) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A held-low break must not be re-read as a string of start bits.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);

endmodule
